stall_controller: RTL and testbench

//  Acts on the hazard detector's Stall request. Drives PC write-enable, IF/ID write-enable,
//  IF/ID flush and ID/EX bubble insertion, and resolves priority between stall, taken branch and halt.

---
 rtl/stall_controller_if.sv | 24 ++
 rtl/stall_controller.sv | 64 ++++++
 tb/tb_stall_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/stall_controller_if.sv
// stall_controller_if: hazard-side request and pipeline-control bus for stall_controller
//   Stall, BranchTaken_D, Halt_D                   requests from hazard detect / decode
//   PCWriteEN, IFIDWriteEN, IFIDFlush, IDEXFlush   pipeline register controls
//   Halted, Watchdog, StallCount                   status and performance counter
interface stall_controller_if #(parameter int COUNT_W = 32);
    logic               Stall;
    logic               BranchTaken_D;
    logic               Halt_D;
    logic               PCWriteEN;
    logic               IFIDWriteEN;
    logic               IFIDFlush;
    logic               IDEXFlush;
    logic               Halted;
    logic               Watchdog;
    logic [COUNT_W-1:0] StallCount;
    modport master (
        output Stall, BranchTaken_D, Halt_D,
        input  PCWriteEN, IFIDWriteEN, IFIDFlush, IDEXFlush, Halted, Watchdog, StallCount
    );
    modport slave (
        input  Stall, BranchTaken_D, Halt_D,
        output PCWriteEN, IFIDWriteEN, IFIDFlush, IDEXFlush, Halted, Watchdog, StallCount
    );
endinterface

// File: rtl/stall_controller.sv
// stall_controller: resolves stall/branch/halt priority into pipeline write-enables and flushes
//   CLK, RESET  clock and synchronous active-high reset
//   bus         slave side of stall_controller_if (requests in, controls and status out)
module stall_controller #(
    parameter int COUNT_W      = 32,
    parameter int MAX_STALL    = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input logic               CLK,
    input logic               RESET,
    stall_controller_if.slave bus
);
    typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;
    state_t             state;
    logic [7:0]         consec;
    logic [7:0]         consec_nx;
    logic [3:0]         drain;
    logic               wd;
    logic [COUNT_W-1:0] count;
    logic               active;
    assign active    = (state == RUN) || (state == STALL);
    assign consec_nx = (consec == 8'hFF) ? consec : consec + 8'd1;
    // Controls are Mealy so a stall request freezes the front end in the same cycle.
    assign bus.PCWriteEN   = !RESET && active && !bus.Stall && !bus.Halt_D;
    assign bus.IFIDWriteEN = !RESET && active && !bus.Stall;
    assign bus.IFIDFlush   = RESET || !active || (!bus.Stall && (bus.Halt_D || bus.BranchTaken_D));
    assign bus.IDEXFlush   = RESET || !active || bus.Stall;
    assign bus.Halted      = !RESET && (state == HALTED);
    assign bus.Watchdog    = !RESET && wd;
    assign bus.StallCount  = count;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= RUN;
            consec <= '0;
            drain  <= '0;
            wd     <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                RUN, STALL: begin
                    if (bus.Stall) begin
                        state  <= STALL;
                        consec <= consec_nx;
                        if (consec_nx == 8'(MAX_STALL)) wd <= 1'b1;
                        if (count != '1) count <= count + COUNT_W'(1);
                    end else begin
                        consec <= '0;
                        if (bus.Halt_D) begin
                            state <= DRAIN;
                            drain <= 4'(DRAIN_CYCLES - 1);
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain == 4'd0) state <= HALTED;
                    else drain <= drain - 4'd1;
                end
                default: state <= HALTED;
            endcase
        end
    end
endmodule

// File: tb/tb_stall_controller.sv
// tb_stall_controller: directed scenario bench for stall_controller
module tb_stall_controller;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 CLK = ~CLK;
    stall_controller_if #(.COUNT_W(32)) bus ();
    stall_controller_if #(.COUNT_W(4))  bus4 ();
    stall_controller #(.COUNT_W(32), .MAX_STALL(16), .DRAIN_CYCLES(3)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );
    stall_controller #(.COUNT_W(4), .MAX_STALL(16), .DRAIN_CYCLES(3)) dut4 (
        .CLK(CLK), .RESET(RESET), .bus(bus4)
    );
    wire [3:0] ctl = {bus.PCWriteEN, bus.IFIDWriteEN, bus.IFIDFlush, bus.IDEXFlush};

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic s, input logic b, input logic h);
        bus.Stall = s;
        bus.BranchTaken_D = b;
        bus.Halt_D = h;
        #1;
    endtask

    task automatic do_reset;
        RESET = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        step;
        RESET = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        bus4.Stall = 1'b0;
        bus4.BranchTaken_D = 1'b0;
        bus4.Halt_D = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        step;
        checks++;
        if (ctl !== 4'b0011) begin errors++; $display("FAIL reset_ctl got %b exp 0011", ctl); end
        checks++;
        if ({bus.Halted, bus.Watchdog} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {bus.Halted, bus.Watchdog}); end
        RESET = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b1100) begin errors++; $display("FAIL run_ctl got %b exp 1100", ctl); end
        checks++;
        if (bus.StallCount !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.StallCount); end
        checks++;
        if (bus4.StallCount !== 4'd0) begin errors++; $display("FAIL reset_count4 got %0d exp 0", bus4.StallCount); end
    endtask

    task automatic test_single_stall;
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (ctl !== 4'b0001) begin errors++; $display("FAIL stall_ctl got %b exp 0001", ctl); end
        step;
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.StallCount !== 32'd1) begin errors++; $display("FAIL stall_count got %0d exp 1", bus.StallCount); end
        checks++;
        if (ctl !== 4'b1100) begin errors++; $display("FAIL after_stall_ctl got %b exp 1100", ctl); end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (ctl !== 4'b0001) begin errors++; $display("FAIL stall_branch_ctl got %b exp 0001", ctl); end
        step;
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if (ctl !== 4'b1110) begin errors++; $display("FAIL branch_ctl got %b exp 1110", ctl); end
        step;
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.StallCount !== 32'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", bus.StallCount); end
    endtask

    task automatic test_priority;
        drive(1'b1, 1'b0, 1'b1);
        checks++;
        if (ctl !== 4'b0001) begin errors++; $display("FAIL stall_over_halt got %b exp 0001", ctl); end
        step;
        drive(1'b0, 1'b1, 1'b1);
        checks++;
        if (ctl !== 4'b0110) begin errors++; $display("FAIL halt_over_branch got %b exp 0110", ctl); end
        step;
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== 4'b0011) begin errors++; $display("FAIL prio_drain_ctl got %b exp 0011", ctl); end
        do_reset;
    endtask

    task automatic test_watchdog;
        do_reset;
        drive(1'b1, 1'b0, 1'b0);
        repeat (15) step;
        checks++;
        if (bus.Watchdog !== 1'b0) begin errors++; $display("FAIL wd_early got %b exp 0", bus.Watchdog); end
        step;
        checks++;
        if (bus.Watchdog !== 1'b1) begin errors++; $display("FAIL wd_set got %b exp 1", bus.Watchdog); end
        checks++;
        if (bus.StallCount !== 32'd16) begin errors++; $display("FAIL wd_count got %0d exp 16", bus.StallCount); end
        drive(1'b0, 1'b0, 1'b0);
        step;
        checks++;
        if ({bus.Watchdog, ctl} !== 5'b11100) begin errors++; $display("FAIL wd_sticky got %b exp 11100", {bus.Watchdog, ctl}); end
    endtask

    task automatic test_halt;
        do_reset;
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (ctl !== 4'b0110) begin errors++; $display("FAIL halt_ctl got %b exp 0110", ctl); end
        step;
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.Halted, ctl} !== 5'b00011) begin errors++; $display("FAIL drain_%0d got %b exp 00011", i, {bus.Halted, ctl}); end
            step;
        end
        checks++;
        if ({bus.Halted, ctl} !== 5'b10011) begin errors++; $display("FAIL halted got %b exp 10011", {bus.Halted, ctl}); end
        checks++;
        if (bus.StallCount !== 32'd0) begin errors++; $display("FAIL halt_count got %0d exp 0", bus.StallCount); end
        drive(1'b0, 1'b0, 1'b0);
        step;
        checks++;
        if (bus.Halted !== 1'b1) begin errors++; $display("FAIL halted_sticky got %b exp 1", bus.Halted); end
    endtask

    task automatic test_reset_in_drain;
        do_reset;
        drive(1'b1, 1'b0, 1'b0);
        step;
        drive(1'b0, 1'b0, 1'b1);
        step;
        drive(1'b0, 1'b0, 1'b0);
        step;
        checks++;
        if ({bus.StallCount, ctl} !== {32'd1, 4'b0011}) begin errors++; $display("FAIL mid_drain got %0d/%b exp 1/0011", bus.StallCount, ctl); end
        RESET = 1'b1;
        step;
        RESET = 1'b0;
        #1;
        checks++;
        if ({bus.Halted, bus.StallCount, ctl} !== {1'b0, 32'd0, 4'b1100}) begin errors++; $display("FAIL drain_abort got %b/%0d/%b exp 0/0/1100", bus.Halted, bus.StallCount, ctl); end
        step;
        checks++;
        if ({bus.Halted, ctl} !== 5'b01100) begin errors++; $display("FAIL drain_abort_run got %b exp 01100", {bus.Halted, ctl}); end
    endtask

    task automatic test_saturate;
        bus4.Stall = 1'b1;
        repeat (14) step;
        checks++;
        if (bus4.StallCount !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d exp 14", bus4.StallCount); end
        repeat (6) step;
        checks++;
        if (bus4.StallCount !== 4'hF) begin errors++; $display("FAIL sat_20 got %0d exp 15", bus4.StallCount); end
        bus4.Stall = 1'b0;
        step;
        checks++;
        if (bus4.StallCount !== 4'hF) begin errors++; $display("FAIL sat_hold got %0d exp 15", bus4.StallCount); end
    endtask

    initial begin
        test_reset;
        test_single_stall;
        test_back_to_back;
        test_priority;
        test_watchdog;
        test_halt;
        test_reset_in_drain;
        test_saturate;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
